cart_mem_responder: RTL

//  Memory-side responder for the cartridge mapper read path. Takes the mapper's physical
//  ROM address and output-enable plus the CPU read strobe, and runs a req/ack read on the

---
 rtl/cart_mem_pkg.sv | 13 +
 rtl/cart_mem_cache1.sv | 42 ++++
 rtl/cart_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cart_mem_pkg.sv
// Shared definitions for the cartridge memory read path.
package cart_mem_pkg;

    localparam int ADDR_W = 25;
    localparam int TIMER_W = 8;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/cart_mem_cache1.sv
// Single-entry read cache: one address/data pair with a valid bit.
// A fill and an invalidate in the same cycle leave the entry invalid.
module cart_mem_cache1
    import cart_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [7:0]        fill_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [7:0]        data
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    // Capture the entry on fill; invalidate takes priority over a same-cycle fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (fill) begin
                addr_q  <= fill_addr;
                data_q  <= fill_data;
                valid_q <= 1'b1;
            end
            if (inval) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign hit  = valid_q & (addr_q == lookup_addr);
    assign data = data_q;

endmodule

// File: rtl/cart_mem_responder.sv
// Memory-side responder for the cartridge mapper read path.
// A rising CPU read strobe either answers from the one-entry cache, answers
// open-bus for addresses outside the loaded image, or runs a req/ack SDRAM
// read while holding the CPU in wait. A request that sees no ack within
// TIMEOUT cycles is abandoned with open-bus data and a sticky error flag.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no SDRAM request outstanding; hits and oor answered here
//  ST_REQ  | sdram_rd held high, waiting for sdram_ack or timeout
module cart_mem_responder
    import cart_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rom_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_oe,
    input  logic              rd,
    input  logic              inval,
    output logic [7:0]        d_to_cpu,
    output logic              wait_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic              err
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         dout_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               req_d;
    logic               err_d;
    logic               err_set;
    logic               fill;
    logic               rd_q;
    logic               start;
    logic               oor;
    logic               hit;
    logic [7:0]         cache_data;

    assign start = rd & ~rd_q & mem_oe;
    assign oor   = (mem_addr >= rom_size);

    cart_mem_cache1 u_cache (
        .clk         (clk),
        .reset_n     (reset_n),
        .fill        (fill),
        .fill_addr   (sdram_addr),
        .fill_data   (sdram_dout),
        .inval       (inval),
        .lookup_addr (mem_addr),
        .hit         (hit),
        .data        (cache_data)
    );

    // Next-state, timer and output-register decisions for the read FSM.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dout_d  = d_to_cpu;
        addr_d  = sdram_addr;
        req_d   = sdram_rd;
        err_set = 1'b0;
        fill    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                if (oor) begin
                    dout_d = OPEN_BUS;
                end else if (hit) begin
                    dout_d = cache_data;
                end else begin
                    addr_d  = mem_addr;
                    req_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_REQ;
                end
            end
        end else begin
            timer_d = timer_q + 1'b1;
            if (sdram_ack) begin
                dout_d  = sdram_dout;
                fill    = 1'b1;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end else if (timer_q == TIMER_LAST) begin
                dout_d  = OPEN_BUS;
                req_d   = 1'b0;
                err_set = 1'b1;
                state_d = ST_IDLE;
            end
        end
        // Reload of the image clears the error even if a timeout lands together with it.
        if (inval) begin
            err_d = 1'b0;
        end else begin
            err_d = err | err_set;
        end
    end

    // State and output registers; reset drops an in-flight request immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            d_to_cpu   <= OPEN_BUS;
            sdram_addr <= '0;
            sdram_rd   <= 1'b0;
            err        <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            d_to_cpu   <= dout_d;
            sdram_addr <= addr_d;
            sdram_rd   <= req_d;
            err        <= err_d;
            rd_q       <= rd;
        end
    end

    // The CPU stalls from the miss-detect cycle until the request resolves.
    assign wait_n = ~reset_n |
                    ~((state_q == ST_REQ) | ((state_q == ST_IDLE) & start & ~oor & ~hit));

endmodule
